dsp_div_seq: RTL
================

// Module: dsp_div_seq
// PURPOSE
//   Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU) for the sail-core ALU.
//   The ALU's add path runs forward on the DSP adder; this block runs subtraction in the reverse direction.
//   It performs one restoring trial-subtract per cycle with a start/done handshake.
//   The ALU stalls the pipeline while busy=1.
// PARAMETERS
//   XLEN    32  operand/result width; only 32 is supported
//   CNT_W   6   iteration counter width; must hold XLEN
// PORTS
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous, active-high
//   start     in   1   request; sampled only in IDLE
//   op        in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in   32  rs1; captured when start is accepted
//   divisor   in   32  rs2; captured when start is accepted
//   busy      out  1   high from the accept edge until done
//   done      out  1   one-cycle pulse; result is valid in that cycle
//   result    out  32  quotient or remainder; held until the next done
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, result=0, internal registers=0.
//     Reset mid-operation aborts at once; no done is emitted.
//   FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE:
//     start=1 -> capture op and operands, busy<=1.
//     Signed ops (DIV, REM): store the magnitudes and latch neg_q=sa^sb and neg_r=sa.
//     Load quotient register with |dividend|, remainder register with 0, cnt<=0.
//     divisor==0 -> skip to FIX; otherwise -> CALC.
//   CALC: each cycle
//     rem' = {rem[30:0], q[31]}
//     diff = rem' - |divisor|, 33-bit, borrow in bit 32
//     borrow=0 -> rem<=diff, shift 1 into q; borrow=1 -> rem<=rem', shift 0 into q.
//     cnt==31 -> FIX.
//   FIX (one cycle):
//     divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend (raw, unsigned).
//     Otherwise: quotient negated if neg_q (signed ops); remainder negated if neg_r (signed ops).
//     The selected value is registered into result.
//   DONE: done=1 for exactly one cycle; busy<=0 on the same edge -> IDLE.
//   Latency:
//     Nonzero divisor: done is high in the 34th cycle after the accept edge.
//     Zero divisor: done is high in the 2nd cycle after the accept edge.
//   Signed overflow (0x80000000 / 0xFFFFFFFF):
//     Falls out of the magnitude path: DIV=0x80000000, REM=0. No special case.
//   start while busy: ignored; operand/op changes during busy: ignored.
//   start may be high in the cycle after done; it is accepted in IDLE (back-to-back).
//   All arithmetic is modulo 2^32 except the 33-bit trial difference.
// CONFIGURATION
//   DSP_DIV_MAC_EN defined:
//     The trial subtract is built from dsp_sub, an SB_MAC16 in 32-bit add/sub mode.
//     ADDSUBTOP=ADDSUBBOT=1; the low half cascades carry into the top half.
//     All SB_MAC16 registers are bypassed, so it stays combinational within CALC.
//     Borrow is taken from CO.
//   DSP_DIV_MAC_EN undefined:
//     Fabric subtract {1'b0,a}-{1'b0,b}.
//   Results and cycle counts are identical in both builds.
// STRUCTURE
//   Shared package dsp_div_pkg.vh:
//     op encodings DIV_OP_DIV/DIVU/REM/REMU
//     state encodings S_IDLE/S_CALC/S_FIX/S_DONE
//     DIV_ITER=32
//     DIV_ZERO_Q=32'hFFFFFFFF
//   Sub-module dsp_sub:
//     33-bit borrow-out subtractor.
//     Wraps SB_MAC16 under DSP_DIV_MAC_EN; fabric otherwise.
//   The divider FSM and datapath live in this file.
// TESTING
//   DIVU 100/7:
//     -> result=14, done exactly 34 cycles after accept, busy high throughout.
//   REM 0xFFFFFFF9/2 (-7/2):
//     -> result=0xFFFFFFFF (-1); DIV on the same operands -> 0xFFFFFFFD (-3).
//   DIV 0x80000000/0xFFFFFFFF:
//     -> 0x80000000; REM on the same operands -> 0x00000000.
//   Divisor 0:
//     DIVU 0x1234/0 -> 0xFFFFFFFF; REMU -> 0x1234; REM 0xFFFFFF00/0 -> 0xFFFFFF00.
//     Each: done 2 cycles after accept.
//   start pulsed at cycle 10 of a DIVU 50/5:
//     -> ignored, result=10; then back-to-back start on the cycle after done -> accepted.
//   reset at CALC cycle 15:
//     -> next cycle busy=0, done=0, result=0; no done pulse; next start completes normally.
//   Run all scenarios with DSP_DIV_MAC_EN defined and undefined; traces must match.

Source files
------------

// File: rtl/dsp_div_pkg.sv
// Shared encodings and helpers for the sequential RV32M divider (dsp_div_seq).
package dsp_div_pkg;

  localparam int          DIV_ITER   = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/dsp_sub.sv
// 32-bit subtractor with borrow out for the divider trial step.
// DSP_DIV_MAC_EN selects an SB_MAC16 in unregistered 32-bit subtract mode; otherwise fabric logic.
module dsp_sub #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

`ifdef DSP_DIV_MAC_EN
  logic co;

  // O = {C,D} - {A,B}; bottom half carries into the top half, nothing is registered.
  SB_MAC16 #(
    .NEG_TRIGGER              (1'b0),
    .C_REG                    (1'b0),
    .A_REG                    (1'b0),
    .B_REG                    (1'b0),
    .D_REG                    (1'b0),
    .TOP_8x8_MULT_REG         (1'b0),
    .BOT_8x8_MULT_REG         (1'b0),
    .PIPELINE_16x16_MULT_REG1 (1'b0),
    .PIPELINE_16x16_MULT_REG2 (1'b0),
    .TOPOUTPUT_SELECT         (2'b00),
    .TOPADDSUB_LOWERINPUT     (2'b00),
    .TOPADDSUB_UPPERINPUT     (1'b1),
    .TOPADDSUB_CARRYSELECT    (2'b10),
    .BOTOUTPUT_SELECT         (2'b00),
    .BOTADDSUB_LOWERINPUT     (2'b00),
    .BOTADDSUB_UPPERINPUT     (1'b1),
    .BOTADDSUB_CARRYSELECT    (2'b00),
    .MODE_8x8                 (1'b0),
    .A_SIGNED                 (1'b0),
    .B_SIGNED                 (1'b0)
  ) u_mac (
    .CLK        (1'b0),
    .CE         (1'b0),
    .C          (a[31:16]),
    .A          (b[31:16]),
    .B          (b[15:0]),
    .D          (a[15:0]),
    .AHOLD      (1'b0),
    .BHOLD      (1'b0),
    .CHOLD      (1'b0),
    .DHOLD      (1'b0),
    .IRSTTOP    (1'b0),
    .IRSTBOT    (1'b0),
    .ORSTTOP    (1'b0),
    .ORSTBOT    (1'b0),
    .OLOADTOP   (1'b0),
    .OLOADBOT   (1'b0),
    .ADDSUBTOP  (1'b1),
    .ADDSUBBOT  (1'b1),
    .OHOLDTOP   (1'b0),
    .OHOLDBOT   (1'b0),
    .CI         (1'b0),
    .ACCUMCI    (1'b0),
    .SIGNEXTIN  (1'b0),
    .O          (diff),
    .CO         (co),
    .ACCUMCO    (),
    .SIGNEXTOUT ()
  );

  assign borrow = co;
`else
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};
`endif

endmodule

// File: rtl/dsp_div_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one trial subtract per cycle.
// Build option DSP_DIV_MAC_EN moves the trial subtract into an SB_MAC16 (see dsp_sub).
module dsp_div_seq
  import dsp_div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q,   state_d;
  div_op_e         op_q,      op_d;
  logic [XLEN-1:0] quo_q,     quo_d;
  logic [XLEN-1:0] rem_q,     rem_d;
  logic [XLEN-1:0] dvsr_q,    dvsr_d;
  logic [XLEN-1:0] dvnd_q,    dvnd_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q,      dz_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;
  logic [XLEN-1:0] result_q,  result_d;

  logic [XLEN-1:0] rem_shift;
  logic [XLEN-1:0] sub_diff;
  logic            sub_borrow;
  logic [XLEN-1:0] fix_value;
  logic            start_signed;

  assign rem_shift = {rem_q[XLEN-2:0], quo_q[XLEN-1]};

  dsp_sub #(.W(XLEN)) u_sub (
    .a      (rem_shift),
    .b      (dvsr_q),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  assign start_signed = op_is_signed(op);

  // Division by zero bypasses the sign fix-up: REM/REMU return the raw dividend.
  always_comb begin
    fix_value = quo_q;
    if (dz_q) begin
      fix_value = op_is_rem(op_q) ? dvnd_q : DIV_ZERO_Q;
    end else if (op_is_rem(op_q)) begin
      fix_value = neg_rem_q ? neg32(rem_q) : rem_q;
    end else begin
      fix_value = neg_quo_q ? neg32(quo_q) : quo_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    dvnd_d    = dvnd_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = div_op_e'(op);
          dvnd_d    = dividend;
          dvsr_d    = start_signed ? abs32(divisor)  : divisor;
          quo_d     = start_signed ? abs32(dividend) : dividend;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = start_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
          neg_rem_d = start_signed & dividend[XLEN-1];
          dz_d      = (divisor == '0);
          busy_d    = 1'b1;
          state_d   = (divisor == '0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = sub_borrow ? rem_shift : sub_diff;
        quo_d = {quo_q[XLEN-2:0], ~sub_borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_value;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= DIV_OP_DIV;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      dvnd_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      dvnd_q    <= dvnd_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
